// File: rtl/jedro_1_mem_reader.sv
`default_nettype none
// ============================================================================
// Module   : jedro_1_mem_reader
// Purpose  : Streams a word-aligned memory region [start, end) out of a
//            request/response memory port into a valid/ready word stream.
//            A small output FIFO plus a credit count keeps responses from
//            ever being backpressured.
// Ports    : clk_i/rst_i        clock, synchronous active-high reset
//            start_i, *_addr_i  region start (inclusive) / end (exclusive)
//            busy_o/done_o/error_o  status (done is a one-cycle pulse)
//            req_*              read request channel (valid/ready)
//            rsp_*              read response channel (valid/ready)
//            out_*              output word stream (valid/ready, last)
// Revision : 1.0 - initial release
// ============================================================================
module jedro_1_mem_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    input  logic [ADDR_WIDTH-1:0] end_addr_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [ADDR_WIDTH-1:0] req_addr_o,
    output logic [DATA_WIDTH-1:0] req_data_o,
    output logic [3:0]            req_strobe_o,
    output logic                  req_write_o,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    input  logic [DATA_WIDTH-1:0] rsp_data_i,
    input  logic                  rsp_error_i,
    input  logic                  rsp_valid_i,
    output logic                  rsp_ready_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_last_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] c_WORD    = ADDR_WIDTH'(4);
    localparam logic [c_PTR_W-1:0]    c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0]    c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W:0]      c_DEPTH   = (c_CNT_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cur_addr;
    logic [ADDR_WIDTH-1:0] r_end_addr;
    logic [ADDR_WIDTH-1:0] r_rsp_addr;   // address of the next response due
    logic [c_CNT_W-1:0]    r_outstanding;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_fifo_last;
    logic                  r_error;

    logic [ADDR_WIDTH-1:0] w_start_al;
    logic [ADDR_WIDTH-1:0] w_end_al;
    logic [ADDR_WIDTH-1:0] w_cur_next;
    logic                  w_accept;
    logic                  w_credit_ok;
    logic                  w_req_valid;
    logic                  w_req_fire;
    logic                  w_rsp_ready;
    logic                  w_rsp_fire;
    logic                  w_fifo_empty;
    logic                  w_pop;
    logic                  w_rsp_last;
    logic                  w_unused;

    assign w_start_al = {start_addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign w_end_al   = {end_addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign w_unused   = ^{start_addr_i[1:0], end_addr_i[1:0]};
    assign w_accept   = (r_state == c_ST_IDLE) && start_i;
    assign w_cur_next = r_cur_addr + c_WORD;

    // Every issued request owns one FIFO slot until its word is popped, so
    // a response push can never find the FIFO full without a matching pop.
    assign w_credit_ok  = ({1'b0, r_outstanding} + {1'b0, r_count}) < c_DEPTH;
    assign w_req_valid  = (r_state == c_ST_RUN) && (r_cur_addr < r_end_addr) && w_credit_ok;
    assign w_req_fire   = w_req_valid && req_ready_i;
    assign w_rsp_ready  = (r_state == c_ST_RUN) || (r_state == c_ST_DRAIN);
    assign w_rsp_fire   = rsp_valid_i && w_rsp_ready;
    assign w_fifo_empty = (r_count == '0);
    assign w_pop        = !w_fifo_empty && out_ready_i;

    // Responses return in request order, so tracking the next response
    // address is enough to recognise the final word of the region.
    assign w_rsp_last = (r_rsp_addr == (r_end_addr - c_WORD)) && !r_error && !rsp_error_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt = (w_start_al >= w_end_al) ? c_ST_DONE : c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if ((w_rsp_fire && rsp_error_i) || (w_req_fire && (w_cur_next == r_end_addr))) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if ((r_outstanding == '0) && w_fifo_empty) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= c_ST_IDLE;
            r_cur_addr    <= '0;
            r_end_addr    <= '0;
            r_rsp_addr    <= '0;
            r_outstanding <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_fifo_last   <= '0;
            r_error       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_accept) begin
                r_cur_addr <= w_start_al;
                r_end_addr <= w_end_al;
                r_rsp_addr <= w_start_al;
                r_error    <= 1'b0;
            end else begin
                if (w_req_fire) begin
                    r_cur_addr <= w_cur_next;
                end
                if (w_rsp_fire) begin
                    r_rsp_addr <= r_rsp_addr + c_WORD;
                    if (rsp_error_i) begin
                        r_error <= 1'b1;
                    end
                end
            end

            if (w_req_fire && !w_rsp_fire) begin
                r_outstanding <= r_outstanding + c_CNT_ONE;
            end else if (!w_req_fire && w_rsp_fire) begin
                r_outstanding <= r_outstanding - c_CNT_ONE;
            end

            if (w_rsp_fire) begin
                r_fifo_last[r_wr_ptr] <= w_rsp_last;
                r_wr_ptr              <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_rsp_fire && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (!w_rsp_fire && w_pop) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (w_rsp_fire) begin
            r_fifo_data[r_wr_ptr] <= rsp_data_i;
        end
    end

    // Control outputs are forced low combinationally while reset is held so
    // a transfer is abandoned in the very cycle reset arrives.
    assign busy_o       = !rst_i && (r_state != c_ST_IDLE);
    assign done_o       = !rst_i && (r_state == c_ST_DONE);
    assign error_o      = !rst_i && r_error;
    assign req_valid_o  = !rst_i && w_req_valid;
    assign req_addr_o   = rst_i ? '0 : r_cur_addr;
    assign req_data_o   = '0;
    assign req_strobe_o = 4'b1111;
    assign req_write_o  = 1'b0;
    assign rsp_ready_o  = !rst_i && w_rsp_ready;
    assign out_valid_o  = !rst_i && !w_fifo_empty;
    assign out_data_o   = r_fifo_data[r_rd_ptr];
    assign out_last_o   = !rst_i && !w_fifo_empty && r_fifo_last[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_jedro_1_mem_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_jedro_1_mem_reader
// Purpose  : Self-checking bench for jedro_1_mem_reader. A behavioural memory
//            (queue of accepted addresses with latency) answers requests and
//            the expected stream is derived from the addresses it served.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jedro_1_mem_reader;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] start_addr_i;
    logic [31:0] end_addr_i;
    logic        busy_o;
    logic        done_o;
    logic        error_o;
    logic [31:0] req_addr_o;
    logic [31:0] req_data_o;
    logic [3:0]  req_strobe_o;
    logic        req_write_o;
    logic        req_valid_o;
    logic        req_ready_i;
    logic [31:0] rsp_data_i;
    logic        rsp_error_i;
    logic        rsp_valid_i;
    logic        rsp_ready_o;
    logic [31:0] out_data_o;
    logic        out_last_o;
    logic        out_valid_o;
    logic        out_ready_i;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] salt    = 32'h0;

    always #5 clk = ~clk;

    jedro_1_mem_reader #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .FIFO_DEPTH(DEPTH)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .start_addr_i(start_addr_i),
        .end_addr_i  (end_addr_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o),
        .req_addr_o  (req_addr_o),
        .req_data_o  (req_data_o),
        .req_strobe_o(req_strobe_o),
        .req_write_o (req_write_o),
        .req_valid_o (req_valid_o),
        .req_ready_i (req_ready_i),
        .rsp_data_i  (rsp_data_i),
        .rsp_error_i (rsp_error_i),
        .rsp_valid_i (rsp_valid_i),
        .rsp_ready_o (rsp_ready_o),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ salt;
    endfunction

    // One region transfer against the memory model. err_word < 0 means no
    // error; stall holds out_ready_i low for that many cycles after start;
    // rnd randomises all ready/valid timing and injects ignored start pulses.
    task automatic run_xfer(input logic [31:0] sa, input logic [31:0] ea,
                            input int err_word, input int stall, input bit rnd);
        logic [31:0] lo, hi, nxt, err_addr, a, wait_addr;
        logic [31:0] mem_q[$];
        int          mem_t[$];
        logic [31:0] exp_d[$];
        bit          exp_l[$];
        int          n_words, n_req, n_out, n_done, busy_cyc;
        bit          has_err, err_seen, rsp_pend, wait_req, saw_valid, finished;
        lo        = {sa[31:2], 2'b00};
        hi        = {ea[31:2], 2'b00};
        n_words   = (hi > lo) ? int'((hi - lo) >> 2) : 0;
        has_err   = (err_word >= 0) && (err_word < n_words);
        err_addr  = lo + 32'(err_word) * 32'd4;
        nxt       = lo;
        wait_addr = '0;
        n_req = 0; n_out = 0; n_done = 0; busy_cyc = 0;
        err_seen = 0; rsp_pend = 0; wait_req = 0; saw_valid = 0; finished = 0;
        salt = $urandom;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            start_i      = (cyc == 0) || (rnd && ($urandom_range(0, 7) == 0));
            start_addr_i = (cyc == 0) ? sa : $urandom;
            end_addr_i   = (cyc == 0) ? ea : $urandom;
            req_ready_i  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            out_ready_i  = (cyc <= stall) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            if (!rsp_pend && mem_q.size() > 0 && mem_t[0] <= cyc &&
                (!rnd || $urandom_range(0, 2) != 0))
                rsp_pend = 1;
            rsp_valid_i = rsp_pend;
            rsp_data_i  = rsp_pend ? mem_data(mem_q[0]) : $urandom;
            rsp_error_i = rsp_pend && has_err && (mem_q[0] == err_addr);
            #1;
            if (busy_o) busy_cyc++;
            if (req_valid_o) saw_valid = 1;
            if (cyc == 1 && n_words > 0) chk("first_req_valid", req_valid_o, 1);
            if (wait_req && !err_seen) begin
                chk("req_hold_valid", req_valid_o, 1);
                chk("req_hold_addr", req_addr_o, wait_addr);
            end
            if (err_seen) chk("req_after_err", req_valid_o, 0);
            // request channel
            wait_req = 0;
            if (req_valid_o) begin
                if (req_ready_i) begin
                    chk("req_addr", req_addr_o, nxt);
                    chk("req_in_region", nxt < hi, 1);
                    chk("credit_bound", (n_req - n_out) < DEPTH, 1);
                    mem_q.push_back(nxt);
                    mem_t.push_back(cyc + 1 + (rnd ? int'($urandom_range(0, 3)) : 0));
                    nxt += 32'd4;
                    n_req++;
                end else begin
                    wait_req  = 1;
                    wait_addr = req_addr_o;
                end
            end
            // output stream
            if (out_valid_o && out_ready_i) begin
                if (exp_d.size() == 0) begin
                    chk("out_unexpected", 1, 0);
                end else begin
                    chk("out_data", out_data_o, exp_d.pop_front());
                    chk("out_last", out_last_o, exp_l.pop_front());
                    n_out++;
                end
            end
            // response channel
            if (rsp_valid_i) begin
                chk("rsp_ready", rsp_ready_o, 1);
                if (rsp_ready_o) begin
                    a = mem_q.pop_front();
                    void'(mem_t.pop_front());
                    if (rsp_error_i) err_seen = 1;
                    exp_d.push_back(mem_data(a));
                    exp_l.push_back((a == hi - 32'd4) && !err_seen);
                    rsp_pend = 0;
                end
            end
            if (done_o) begin
                n_done++;
                chk("err_flag", error_o, has_err);
                finished = 1;
            end
        end
        if (!finished) chk("timeout_done", 0, 1);
        @(negedge clk);
        start_i     = 0;
        rsp_valid_i = 0;
        rsp_error_i = 0;
        #1;
        chk("done_single_pulse", done_o, 0);
        chk("idle_after_done", busy_o, 0);
        chk("done_count", n_done, 1);
        chk("out_count", n_out, n_req);
        chk("rsp_all_taken", mem_q.size(), 0);
        if (!has_err) chk("req_count", n_req, n_words);
        if (n_words == 0) begin
            chk("empty_busy_cycles", busy_cyc, 1);
            chk("empty_no_req", saw_valid, 0);
        end
    endtask

    task automatic reset_midrun();
        int cnt;
        cnt = 0;
        @(negedge clk);
        start_i      = 1;
        start_addr_i = 32'h400;
        end_addr_i   = 32'h440;
        req_ready_i  = 1;
        rsp_valid_i  = 0;
        out_ready_i  = 1;
        for (int c = 0; c < 20 && cnt < 2; c++) begin
            #1;
            if (req_valid_o && req_ready_i) cnt++;
            @(negedge clk);
            start_i = 0;
        end
        chk("rst_two_outstanding", cnt, 2);
        rst_i = 1;
        #1;
        chk("rst_cycle_busy", busy_o, 0);
        chk("rst_cycle_req_valid", req_valid_o, 0);
        @(negedge clk);
        rst_i = 0;
        #1;
        chk("rst_after_busy", busy_o, 0);
        chk("rst_after_out_valid", out_valid_o, 0);
        chk("rst_after_req_valid", req_valid_o, 0);
        // late responses for the abandoned requests must be refused
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            rsp_valid_i = 1;
            rsp_data_i  = 32'hDEAD_0000 + 32'(c);
            #1;
            chk("late_rsp_ready", rsp_ready_o, 0);
            chk("late_rsp_out_valid", out_valid_o, 0);
        end
        @(negedge clk);
        rsp_valid_i = 0;
        run_xfer(32'h500, 32'h510, -1, 0, 0);
    endtask

    initial begin
        logic [31:0] sa, ea;
        rst_i        = 1;
        start_i      = 0;
        start_addr_i = '0;
        end_addr_i   = '0;
        req_ready_i  = 0;
        rsp_data_i   = '0;
        rsp_error_i  = 0;
        rsp_valid_i  = 0;
        out_ready_i  = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_error", error_o, 0);
        chk("rst_req_valid", req_valid_o, 0);
        chk("rst_rsp_ready", rsp_ready_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_out_last", out_last_o, 0);
        chk("rst_req_addr", req_addr_o, 0);
        chk("tie_strobe", req_strobe_o, 4'hF);
        chk("tie_write", req_write_o, 0);
        chk("tie_data", req_data_o, 0);
        @(negedge clk);
        rst_i = 0;

        run_xfer(32'h100, 32'h110, -1, 0, 0);   // four words, last on 0x10C
        run_xfer(32'h200, 32'h200, -1, 0, 0);   // empty region
        run_xfer(32'h103, 32'h10B, -1, 0, 0);   // unaligned bounds
        run_xfer(32'h300, 32'h320, -1, 20, 0);  // 8 words, consumer stalled
        run_xfer(32'h600, 32'h618, 1, 0, 0);    // error on 2nd of 6 words
        reset_midrun();
        run_xfer(32'hFFFF_FFE0, 32'hFFFF_FFFC, -1, 0, 1);

        for (int t = 0; t < 25; t++) begin
            sa = 32'h1000 + $urandom_range(0, 255);
            if ($urandom_range(0, 7) == 0) ea = sa - $urandom_range(0, 16);
            else                           ea = sa + $urandom_range(0, 70);
            run_xfer(sa, ea, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1,
                     int'($urandom_range(0, 10)), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jedro_1_mem_reader.md
JEDRO_1_MEM_READER -- requirements
Module: jedro_1_mem_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the request and response data words.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, width of the byte address.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, number of entries in the output word FIFO; legal values are powers of two from 2 to 8.
REQ-004 SHALL have ports, listed as name, direction, width, meaning:
  clk_i  in  1  single clock; all logic samples on the rising edge.
  rst_i  in  1  reset, synchronous, active-high.
  start_i  in  1  start pulse, sampled only in IDLE.
  start_addr_i  in  ADDR_WIDTH  first byte address of the region, inclusive.
  end_addr_i  in  ADDR_WIDTH  end byte address of the region, exclusive.
  busy_o  out  1  high in every state except IDLE.
  done_o  out  1  one-cycle completion pulse.
  error_o  out  1  sticky error flag, cleared on the next accepted start.
  req_addr_o  out  ADDR_WIDTH  read address, word aligned.
  req_data_o  out  DATA_WIDTH  tied to 0.
  req_strobe_o  out  4  tied to 4'b1111.
  req_write_o  out  1  tied to 0.
  req_valid_o / req_ready_i  out / in  1 each  request handshake.
  rsp_data_i  in  DATA_WIDTH  read data.
  rsp_error_i  in  1  response error.
  rsp_valid_i / rsp_ready_o  in / out  1 each  response handshake.
  out_data_o  out  DATA_WIDTH  streamed word.
  out_last_o  out  1  marks the final word of the region.
  out_valid_o / out_ready_i  out / in  1 each  stream handshake.

Function
REQ-005 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-006 In IDLE, start_i=1 SHALL latch start_addr_i[ADDR_WIDTH-1:2],2'b00 as the current address and end_addr_i[ADDR_WIDTH-1:2],2'b00 as the end address, clear error_o, and move to RUN.
REQ-007 If the aligned start address is greater than or equal to the aligned end address, the block SHALL move from IDLE directly to DONE and issue no request.
REQ-008 A transfer on either handshake SHALL occur on a cycle when valid and ready are both high.
REQ-009 In RUN, req_valid_o SHALL be high whenever current address < end address and credits > 0, where credits = FIFO_DEPTH - (outstanding + fifo_count).
REQ-010 Once req_valid_o is raised, it and req_addr_o SHALL remain stable until req_ready_i is seen high.
REQ-011 The first req_valid_o SHALL assert in the cycle after start_i is accepted.
REQ-012 Each request transfer SHALL increment the outstanding count and add 4 to the current address, with modulo 2^ADDR_WIDTH wrap-around.
REQ-013 rsp_ready_o SHALL be high in RUN and in DRAIN.
REQ-014 Each response transfer SHALL push rsp_data_i into the FIFO and decrement the outstanding count.
REQ-015 The credit scheme of REQ-009 guarantees that a response push never overflows the FIFO; the block SHALL add no other backpressure on responses.
REQ-016 A simultaneous request transfer and response transfer in one cycle SHALL leave the outstanding count unchanged.
REQ-017 out_valid_o SHALL equal "FIFO not empty"; out_data_o SHALL be the FIFO head.
REQ-018 The FIFO SHALL support a push and a pop in the same cycle, including when it is full.
REQ-019 out_last_o SHALL be high with the head word only when that word was read from end address - 4 and no error has occurred.
REQ-020 A response with rsp_error_i=1 SHALL set error_o, still push its data, stop all further requests, and move RUN to DRAIN.
REQ-021 RUN SHALL move to DRAIN when the last request is transferred.
REQ-022 DRAIN SHALL move to DONE when the outstanding count is 0 and the FIFO is empty.
REQ-023 DONE SHALL pulse done_o for exactly one cycle and return to IDLE on the next cycle.
REQ-024 start_i SHALL be ignored in every state other than IDLE.
REQ-025 The outstanding counter SHALL be log2(FIFO_DEPTH)+1 bits wide and SHALL never exceed FIFO_DEPTH.

Reset
REQ-026 While rst_i=1 at a clock edge, the block SHALL enter IDLE and clear the FIFO, the outstanding count and both addresses.
REQ-027 While rst_i=1 at a clock edge, the block SHALL drive busy_o, done_o, error_o, req_valid_o, rsp_ready_o, out_valid_o and out_last_o to 0, and req_addr_o to 0.
REQ-028 Reset asserted during RUN or DRAIN SHALL abandon the transfer within the same cycle.
REQ-029 After reset, any late responses SHALL be ignored, because rsp_ready_o is 0 in IDLE.

Verification
REQ-030 The bench SHALL cover: start 0x100, end 0x110, always-ready memory with 1-cycle latency, out_ready_i=1 -> reads 0x100, 0x104, 0x108, 0x10C in order; four out words; out_last_o only on the 0x10C word; one done_o pulse; error_o=0.
REQ-031 The bench SHALL cover: start 0x200, end 0x200 -> no req_valid_o; done_o in the second cycle after start; busy_o high for exactly 1 cycle.
REQ-032 The bench SHALL cover: start 0x103, end 0x10B -> reads 0x100 and 0x104 only, and the 0x104 word is marked last.
REQ-033 The bench SHALL cover: out_ready_i=0 for 20 cycles, region of 8 words -> at most FIFO_DEPTH requests issued, no response lost; after release, all 8 words arrive in order.
REQ-034 The bench SHALL cover: rsp_error_i=1 on the 2nd of 6 words -> error_o=1; no new request after that response; outstanding words drained; out_last_o never asserted; done_o pulses.
REQ-035 The bench SHALL cover: rst_i=1 mid-RUN with 2 requests outstanding -> next cycle busy_o=0, out_valid_o=0; a new start then completes normally.
